// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: forward-select width helper, register-file select code
// and the per-stage scoreboard entry.
package cpu_pipe_pkg;

  localparam int FWD_RF  = 0;
  // Widest register address a stage entry can hold; narrower AW is zero-extended.
  localparam int RD_MAXW = 8;

  typedef logic [RD_MAXW-1:0] rd_t;

  typedef struct packed {
    logic v;
    logic wr;
    logic ld;
    rd_t  rd;
  } stage_ent_t;

  function automatic int sel_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_port_match.sv
// One decode read port: youngest-writer priority match, forward select and
// load-use hazard flag.
module hazard_port_match
  import cpu_pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int AW         = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SW         = 2
) (
  input  logic                    rs_used,
  input  logic [AW-1:0]           rs,
  input  stage_ent_t [STAGES:1]   ents,
  output logic [SW-1:0]           sel,
  output logic                    haz
);

  always_comb begin
    logic found;
    found = 1'b0;
    sel   = SW'(FWD_RF);
    haz   = 1'b0;
    // Scan from stage 1 so the youngest writer claims the port first.
    for (int k = 1; k <= STAGES; k++) begin
      if (!found && rs_used && (rs != '0) && ents[k].v && ents[k].wr &&
          (ents[k].rd != '0) && (ents[k].rd == rd_t'(rs))) begin
        found = 1'b1;
        if (ents[k].ld && (k < LOAD_STAGE)) haz = 1'b1;
        else                                sel = SW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks destination registers in flight,
// drives per-port forward selects and stalls decode on load-use hazards.
module hazard_scoreboard
  import cpu_pipe_pkg::*;
#(
  parameter  int STAGES     = 3,
  parameter  int AW         = 5,
  parameter  int RPORTS     = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SW         = sel_w(STAGES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [RPORTS*AW-1:0]   id_rs,
  input  logic [RPORTS-1:0]      id_rs_used,
  input  logic                   id_wr_en,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   ext_stall,
  output logic                   stall,
  output logic                   issue,
  output logic [RPORTS*SW-1:0]   fwd_sel,
  output logic [15:0]            stall_cnt
);

  stage_ent_t [STAGES:1] ents;
  logic [RPORTS-1:0]     port_haz;
  logic                  hazard;
  logic                  haz_stall;

  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    hazard_port_match #(
      .STAGES     (STAGES),
      .AW         (AW),
      .LOAD_STAGE (LOAD_STAGE),
      .SW         (SW)
    ) u_match (
      .rs_used (id_rs_used[p]),
      .rs      (id_rs[p*AW +: AW]),
      .ents    (ents),
      .sel     (fwd_sel[p*SW +: SW]),
      .haz     (port_haz[p])
    );
  end

  assign hazard    = |port_haz;
  // A flushed decode slot cannot cause a hazard stall.
  assign haz_stall = hazard & id_valid & ~flush;
  assign stall     = haz_stall | ext_stall;
  assign issue     = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ents      <= '0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      for (int k = STAGES; k >= 2; k--) ents[k] <= ents[k-1];
      ents[1] <= issue ? '{v: 1'b1, wr: id_wr_en, ld: id_is_load, rd: rd_t'(id_rd)}
                       : '0;
      if (haz_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
